// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel
// clamped targets, per-frame slew limiting and frame-aligned enables.
module servo_pwm_multi #(
    parameter int N_CH   = 4,
    parameter int PERIOD = 1_000_000,
    parameter int CNT_W  = 21,
    parameter int PW_MIN = 50_000,
    parameter int PW_MAX = 250_000,
    parameter int STEP   = 1_000
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         wr_en,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]   wr_ch,
    input  logic [CNT_W-1:0]                             wr_pw,
    input  logic [N_CH-1:0]                              enable,
    output logic [N_CH-1:0]                              servo,
    output logic [N_CH-1:0]                              busy,
    output logic                                         frame_tick
);

    localparam int                CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  MIN_V  = CNT_W'(PW_MIN);
    localparam logic [CNT_W-1:0]  MAX_V  = CNT_W'(PW_MAX);
    localparam logic [CNT_W-1:0]  PW_CTR = CNT_W'((PW_MIN + PW_MAX) / 2);
    localparam logic [CNT_W-1:0]  STEP_V = CNT_W'(STEP);
    localparam logic signed [CNT_W:0] STEP_S = (CNT_W + 1)'(STEP);

    function automatic logic [CNT_W-1:0] clamp_pw(input logic [CNT_W-1:0] pw);
        if (pw < MIN_V)
            return MIN_V;
        else if (pw > MAX_V)
            return MAX_V;
        else
            return pw;
    endfunction

    // Difference is taken one bit wider and signed so a downward move never wraps.
    function automatic logic [CNT_W-1:0] slew_pw(input logic [CNT_W-1:0] cur_v,
                                                 input logic [CNT_W-1:0] tgt_v);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, tgt_v}) - $signed({1'b0, cur_v});
        if (STEP == 0)
            return tgt_v;
        else if (diff > STEP_S)
            return cur_v + STEP_V;
        else if (diff < -STEP_S)
            return cur_v - STEP_V;
        else
            return tgt_v;
    endfunction

    logic [CNT_W-1:0] cnt_p0;
    logic             last_p0;
    logic [CNT_W-1:0] tgt [N_CH];
    logic [CNT_W-1:0] cur [N_CH];
    logic [N_CH-1:0]  en_l;
    logic [N_CH-1:0]  servo_p1;

    assign last_p0 = (cnt_p0 == LAST);

    // Stage 0: free-running frame counter
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_p0 <= '0;
        else if (last_p0)
            cnt_p0 <= '0;
        else
            cnt_p0 <= cnt_p0 + CNT_W'(1);
    end

    // Stage 1: per-channel state and registered outputs; the boundary reads the
    // old target, so a write on the boundary edge lands one frame later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_l     <= '0;
            servo_p1 <= '0;
            for (int i = 0; i < N_CH; i++) begin
                tgt[i] <= PW_CTR;
                cur[i] <= PW_CTR;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                servo_p1[i] <= en_l[i] & (cnt_p0 < cur[i]);
                if (last_p0)
                    cur[i] <= slew_pw(cur[i], tgt[i]);
                if (wr_en && (wr_ch == CH_W'(i)))
                    tgt[i] <= clamp_pw(wr_pw);
            end
            if (last_p0)
                en_l <= enable;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < N_CH; i++)
            busy[i] = (cur[i] != tgt[i]);
    end

    assign servo      = servo_p1;
    assign frame_tick = last_p0;

endmodule
